// File: rtl/packet_arbiter_pkg.sv
// rtl/packet_arbiter_pkg.sv - shared constants and state encoding for packet_arbiter
//
// Purpose : default packet width and the arbiter FSM state type.
// Ports   : none (package).

package packet_arbiter_pkg;

  localparam int PACKET_WIDTH_DEFAULT = 175;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_SEND   = 2'd2
  } state_t;

endpackage

// File: rtl/packet_arbiter_rr_pick.sv
// rtl/packet_arbiter_rr_pick.sv - combinational round-robin pick of the next requester
//
// Purpose : choose the first requesting port after i_last, wrapping modulo NUM_PORTS.
// Ports   : i_req   [NUM_PORTS]  request vector
//           i_last  [SRC_WIDTH]  most recently served port
//           o_grant [SRC_WIDTH]  chosen port (0 when nothing requests)
//           o_any                at least one request is present

module packet_arbiter_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int SRC_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SRC_WIDTH-1:0] i_last,
  output logic [SRC_WIDTH-1:0] o_grant,
  output logic                 o_any
);

  int w_dist;
  int w_best;

  assign o_any = |i_req;

  // Each port gets a rotated distance from i_last+1; the closest requester wins.
  // Only real port indices are ever assigned, so non power-of-two counts are safe.
  always_comb begin
    o_grant = '0;
    w_best  = NUM_PORTS;
    w_dist  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dist = i - int'(i_last) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_PORTS;
      end
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = SRC_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin merge of NUM_PORTS packet streams into one
//
// Purpose : forwards one packet at a time from the fairly chosen input port,
//           holding it in a single output register until downstream accepts.
// Ports   : CLK, RST (sync, active high)
//           RECEIVE_PC_VALID/DATA in, RECEIVE_PC_READY out (one-cycle pulse)
//           SEND_PC_VALID/DATA/SRC out, SEND_PC_READY in

module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEFAULT,
  parameter int NUM_PORTS    = 4,
  parameter int SRC_WIDTH    = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_PORTS-1:0]              RECEIVE_PC_VALID,
  input  logic [NUM_PORTS*PACKET_WIDTH-1:0] RECEIVE_PC_DATA,
  output logic [NUM_PORTS-1:0]              RECEIVE_PC_READY,
  output logic                              SEND_PC_VALID,
  output logic [PACKET_WIDTH-1:0]           SEND_PC_DATA,
  output logic [SRC_WIDTH-1:0]              SEND_PC_SRC,
  input  logic                              SEND_PC_READY
);

  state_t                   r_state;
  logic [SRC_WIDTH-1:0]     r_grant;
  logic [SRC_WIDTH-1:0]     r_last;
  logic [NUM_PORTS-1:0]     r_recv_ready;
  logic                     r_send_valid;
  logic [PACKET_WIDTH-1:0]  r_send_data;
  logic [SRC_WIDTH-1:0]     r_send_src;

  logic [SRC_WIDTH-1:0]     w_grant;
  logic                     w_any;
  logic [PACKET_WIDTH-1:0]  w_port_data [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slice
    assign w_port_data[g] = RECEIVE_PC_DATA[g*PACKET_WIDTH +: PACKET_WIDTH];
  end

  packet_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_rr_pick (
    .i_req   (RECEIVE_PC_VALID),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      // Last served = highest port, so port 0 is searched first after reset.
      r_last       <= SRC_WIDTH'(NUM_PORTS - 1);
      r_recv_ready <= '0;
      r_send_valid <= 1'b0;
      r_send_data  <= '0;
      r_send_src   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant      <= w_grant;
            r_recv_ready <= NUM_PORTS'(1) << w_grant;
            r_state      <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          r_recv_ready <= '0;
          if (RECEIVE_PC_VALID[r_grant]) begin
            r_send_data  <= w_port_data[r_grant];
            r_send_src   <= r_grant;
            r_last       <= r_grant;
            r_send_valid <= 1'b1;
            r_state      <= S_SEND;
          end else begin
            // Sender withdrew VALID while READY was up: drop the grant, keep fairness pointer.
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (r_send_valid && SEND_PC_READY) begin
            r_send_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_recv_ready <= '0;
          r_send_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign RECEIVE_PC_READY = r_recv_ready;
  assign SEND_PC_VALID    = r_send_valid;
  assign SEND_PC_DATA     = r_send_data;
  assign SEND_PC_SRC      = r_send_src;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - scoreboard bench for packet_arbiter

module tb_packet_arbiter;

  localparam int PW = 175;
  localparam int NP = 4;

  typedef struct packed {
    logic [1:0]    src;
    logic [PW-1:0] data;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [NP-1:0]    recv_valid;
  logic [NP*PW-1:0] recv_data;
  logic [NP-1:0]    recv_ready;
  logic             send_valid;
  logic [PW-1:0]    send_data;
  logic [1:0]       send_src;
  logic             send_ready;

  exp_t sb[$];
  int   pend [NP];
  int   seq  [NP];
  int   checks;
  int   failures;
  int   cyc;
  int   prev_hs;
  bit   chk_spacing;

  packet_arbiter #(
    .PACKET_WIDTH (PW),
    .NUM_PORTS    (NP),
    .SRC_WIDTH    (2)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .RECEIVE_PC_VALID (recv_valid),
    .RECEIVE_PC_DATA  (recv_data),
    .RECEIVE_PC_READY (recv_ready),
    .SEND_PC_VALID    (send_valid),
    .SEND_PC_DATA     (send_data),
    .SEND_PC_SRC      (send_src),
    .SEND_PC_READY    (send_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(int port, int s);
    logic [PW-1:0] d;
    d            = '0;
    d[7:0]       = 8'hA5 + 8'(s);
    d[15:8]      = 8'(port);
    d[131:100]   = 32'hC0DE0000 | 32'(port * 16 + s);
    d[174:160]   = 15'h1A5A ^ 15'(s);
    return d;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      recv_valid[i]          = (pend[i] > 0);
      recv_data[i*PW +: PW]  = mk(i, seq[i]);
    end
  endtask

  // Advance one clock; upstream senders retire a packet on each VALID&READY edge.
  task automatic tick();
    logic [NP-1:0] xfer;
    xfer = recv_valid & recv_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (xfer[i]) begin
        seq[i]++;
        pend[i]--;
      end
    end
    refresh();
  endtask

  task automatic load(int port, int n);
    pend[port] = n;
    refresh();
  endtask

  task automatic expect_pkt(int port, int s);
    exp_t e;
    e.src  = 2'(port);
    e.data = mk(port, s);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    send_ready = 1'b0;
    for (int i = 0; i < NP; i++) begin
      pend[i] = 0;
      seq[i]  = 0;
    end
    refresh();
    tick();
    tick();
    rst = 1'b0;
    prev_hs = -1;
  endtask

  task automatic drain(string name);
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check(name, 256'(sb.size()), 256'(0));
    sb.delete();
    tick();
    tick();
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot0", 256'($onehot0(recv_ready) && !(|recv_ready && send_valid)), 256'(1));
      if (send_valid && send_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual src=%0d data=%0h required=none", send_src, send_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_src", 256'(send_src), 256'(e.src));
          check("sb_data", 256'(send_data), 256'(e.data));
        end
        if (chk_spacing && prev_hs >= 0) begin
          check("spacing", 256'(cyc - prev_hs), 256'(3));
        end
        prev_hs = cyc;
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    prev_hs = -1;
    chk_spacing = 1'b0;
    rst = 1'b1;
    send_ready = 1'b0;
    recv_valid = '0;
    recv_data = '0;

    // Reset, then a single request on port 2.
    do_reset();
    check("rst_ready", 256'(recv_ready), 256'(0));
    check("rst_valid", 256'(send_valid), 256'(0));
    check("rst_data", 256'(send_data), 256'(0));
    check("rst_src", 256'(send_src), 256'(0));
    send_ready = 1'b1;
    load(2, 1);
    expect_pkt(2, 0);
    tick();
    check("t1_ready", 256'(recv_ready), 256'(4'b0100));
    check("t1_valid_early", 256'(send_valid), 256'(0));
    tick();
    check("t1_valid", 256'(send_valid), 256'(1));
    check("t1_src", 256'(send_src), 256'(2));
    check("t1_data_lo", 256'(send_data[7:0]), 256'(8'hA5));
    drain("t1_drain");

    // All four ports continuously valid: rotation and 3-cycle spacing.
    do_reset();
    send_ready = 1'b1;
    chk_spacing = 1'b1;
    for (int i = 0; i < NP; i++) pend[i] = 2;
    refresh();
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < NP; p++) expect_pkt(p, s);
    drain("t2_drain");
    chk_spacing = 1'b0;

    // Backpressure on port 1 while port 3 also waits.
    do_reset();
    load(1, 1);
    load(3, 1);
    expect_pkt(1, 0);
    expect_pkt(3, 0);
    tick();
    check("bp_ready", 256'(recv_ready), 256'(4'b0010));
    tick();
    check("bp_valid", 256'(send_valid), 256'(1));
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold", 256'(send_valid == 1'b1 && send_data == mk(1, 0) &&
                            send_src == 2'd1 && recv_ready == 4'b0000), 256'(1));
    end
    send_ready = 1'b1;
    tick();
    check("bp_release_valid", 256'(send_valid), 256'(0));
    check("bp_release_ready", 256'(recv_ready), 256'(0));
    tick();
    check("bp_next_ready", 256'(recv_ready), 256'(4'b1000));
    drain("t3_drain");

    // Fairness after a skip: LAST=1, ports 0 and 3 request.
    do_reset();
    send_ready = 1'b1;
    load(1, 1);
    expect_pkt(1, 0);
    drain("t4a_drain");
    load(0, 1);
    load(3, 1);
    expect_pkt(3, 0);
    expect_pkt(0, 0);
    tick();
    check("fair_ready", 256'(recv_ready), 256'(4'b1000));
    drain("t4_drain");

    // Protocol violation: port 0 drops VALID while its READY is high.
    do_reset();
    send_ready = 1'b1;
    load(0, 1);
    tick();
    check("pv_ready", 256'(recv_ready), 256'(4'b0001));
    load(0, 0);
    tick();
    check("pv_no_ready", 256'(recv_ready), 256'(0));
    check("pv_no_valid", 256'(send_valid), 256'(0));
    tick();
    check("pv_idle_valid", 256'(send_valid), 256'(0));
    load(0, 1);
    load(3, 1);
    expect_pkt(0, 0);
    expect_pkt(3, 0);
    tick();
    check("pv_last_kept", 256'(recv_ready), 256'(4'b0001));
    drain("t5_drain");

    // Reset while holding a packet in S_SEND.
    do_reset();
    load(2, 1);
    tick();
    tick();
    check("rs_valid", 256'(send_valid), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_valid_cleared", 256'(send_valid), 256'(0));
    check("rs_data_cleared", 256'(send_data), 256'(0));
    check("rs_src_cleared", 256'(send_src), 256'(0));
    send_ready = 1'b1;
    load(0, 1);
    load(3, 1);
    expect_pkt(0, 0);
    expect_pkt(3, 0);
    tick();
    check("rs_next_grant", 256'(recv_ready), 256'(4'b0001));
    drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_arbiter.md
Name: packet_arbiter

Overview:
- Round-robin arbiter that merges NUM_PORTS independent packet streams into one packet stream, typically placed in front of the packet queue input.
- Uses the codebase's packet handshake on both sides:
  - The sender holds VALID and DATA until it sees READY.
  - A transfer happens on any cycle where VALID and READY are both high.
  - The receiver's READY is a registered one-cycle pulse.
- Forwards one packet at a time, with no internal buffering beyond a single output register.

Parameters:
- PACKET_WIDTH, 175, width of one packet (shared parameter include).
- NUM_PORTS, 4, number of requesting streams, 2..16.
- SRC_WIDTH, 2, width of the source index; must equal clog2(NUM_PORTS).

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- RECEIVE_PC_VALID  in  NUM_PORTS  per-port packet valid; bit i belongs to port i.
- RECEIVE_PC_DATA  in  NUM_PORTS*PACKET_WIDTH  per-port packet; port i occupies bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- RECEIVE_PC_READY  out  NUM_PORTS  per-port ready pulse; registered, at most one bit high (one-hot or zero).
- SEND_PC_VALID  out  1  output packet valid; registered.
- SEND_PC_DATA  out  PACKET_WIDTH  output packet; registered.
- SEND_PC_SRC  out  SRC_WIDTH  index of the port that supplied SEND_PC_DATA; registered.
- SEND_PC_READY  in  1  downstream ready.

Behaviour:
- Reset values:
  - RECEIVE_PC_READY = 0, SEND_PC_VALID = 0, SEND_PC_DATA = 0, SEND_PC_SRC = 0.
  - STATE = S_IDLE, GRANT = 0.
  - LAST = NUM_PORTS-1, so port 0 has first priority after reset.
- Reset asserted in any state aborts the operation in flight:
  - A packet that is accepted but not yet sent is dropped.
  - Outputs take their reset values on the next edge.
- State machine, STATE in {S_IDLE, S_ACCEPT, S_SEND}:
  - S_IDLE, when any RECEIVE_PC_VALID bit is high:
    - GRANT <= the first port with valid high, searching LAST+1, LAST+2, ... modulo NUM_PORTS.
    - RECEIVE_PC_READY <= one-hot(GRANT).
    - STATE <= S_ACCEPT.
    - Arbitration uses the valid bits sampled in this cycle only.
  - S_ACCEPT, when RECEIVE_PC_VALID[GRANT] is high (transfer cycle):
    - SEND_PC_DATA <= slice GRANT of RECEIVE_PC_DATA.
    - SEND_PC_SRC <= GRANT, LAST <= GRANT.
    - SEND_PC_VALID <= 1, RECEIVE_PC_READY <= 0.
    - STATE <= S_SEND.
  - S_ACCEPT, when RECEIVE_PC_VALID[GRANT] is low (protocol violation):
    - RECEIVE_PC_READY <= 0, STATE <= S_IDLE.
    - LAST is unchanged and no output is produced.
  - S_SEND, when SEND_PC_VALID and SEND_PC_READY are both high:
    - SEND_PC_VALID <= 0, STATE <= S_IDLE.
  - S_SEND, otherwise: hold all outputs.
- RECEIVE_PC_READY:
  - Is high for exactly one cycle per grant.
  - Is never high in S_IDLE or S_SEND.
  - Is never high for a port other than GRANT.
- SEND_PC_DATA and SEND_PC_SRC stay stable whenever SEND_PC_VALID is high.
- Latency:
  - Input VALID first seen at cycle t → READY high at t+1 → SEND_PC_VALID high at t+2.
  - With SEND_PC_READY tied high, the next packet's READY comes at t+4, i.e. one packet per 3 cycles.
- Fairness:
  - With all ports continuously valid, grants rotate 0,1,..,NUM_PORTS-1,0,...
  - Maximum wait for any valid port is NUM_PORTS-1 packets.
- Simultaneous events:
  - A new VALID arriving during S_ACCEPT or S_SEND is only considered at the next S_IDLE.
  - Ports not granted keep their VALID held (upstream rule) and receive no READY.
- Backpressure: SEND_PC_READY held low keeps the block in S_SEND indefinitely, and no RECEIVE_PC_READY is issued meanwhile.
- Arithmetic and widths:
  - The pointer search wraps modulo NUM_PORTS.
  - When NUM_PORTS is not a power of two, indices ≥ NUM_PORTS are never produced.

Decomposition:
- Shared parameter include: PACKET_WIDTH.
- Shared macro include: state encodings S_IDLE=2'd0, S_ACCEPT=2'd1, S_SEND=2'd2.
- Shared macro include: the existing send-side VALID macro, reused for SEND_PC_VALID.
- One natural sub-module, rr_pick:
  - Combinational.
  - Inputs: request vector and LAST.
  - Outputs: GRANT index and an any-request flag.

Test Plan:
- Reset then single request:
  - Stimulus: port 2 VALID=1, DATA=0x...A5, SEND_PC_READY=1.
  - Required: RECEIVE_PC_READY=4'b0100 one cycle later; SEND_PC_VALID=1 with DATA=0x...A5 and SRC=2 two cycles after VALID.
- All four ports valid continuously, SEND_PC_READY=1:
  - Required: SRC sequence 0,1,2,3,0,1; one packet every 3 cycles; RECEIVE_PC_READY always one-hot or zero.
- Backpressure:
  - Stimulus: port 1 valid, SEND_PC_READY=0 for 10 cycles, then 1.
  - Required: SEND_PC_VALID, DATA and SRC stable for all 10 cycles; no RECEIVE_PC_READY issued; S_IDLE on the cycle after the handshake.
- Fairness after a skip:
  - Stimulus: LAST=1; ports 0 and 3 valid.
  - Required: grant order 3 then 0.
- Protocol violation:
  - Stimulus: port 0 drops VALID in the cycle its READY is high.
  - Required: no SEND_PC_VALID; return to S_IDLE; LAST unchanged.
- Reset in S_SEND:
  - Stimulus: RST=1 for one cycle while SEND_PC_VALID=1 and SEND_PC_READY=0.
  - Required: SEND_PC_VALID=0 and DATA=0 on the next edge; next grant goes to port 0.
